// File: rtl/scan_alu_pkg.sv
// scan_alu_pkg -- shared definitions for the scan-controlled ALU.
// Contents:
//   op_e      : 3-bit opcode encoding held in the top field of the shadow register
//   calc_iw() : width of the scan shift/shadow register (opcode + dst + payload)
package scan_alu_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_WRITE = 3'b000,
    OP_ADD   = 3'b001,
    OP_SUB   = 3'b010,
    OP_AND   = 3'b011,
    OP_OR    = 3'b100,
    OP_XOR   = 3'b101,
    OP_BUF   = 3'b110,
    OP_NOP   = 3'b111
  } op_e;

  // Instruction word: {op, dst, payload}
  function automatic int calc_iw(input int data_w, input int addr_w);
    return OP_W + addr_w + data_w;
  endfunction

endpackage

// File: rtl/scan_alu_core.sv
// scan_alu_core -- purely combinational ALU.
// Ports:
//   op_i     : opcode
//   a_i, b_i : memory operands (DATA_W bits)
//   result_o : DATA_W+1 bit result; the top bit is the carry (ADD), the borrow (SUB),
//              or 0 (logic ops). WRITE/BUF/NOP return 0; the top module handles those.
module scan_alu_core
  import scan_alu_pkg::*;
#(
  parameter int DATA_W = 4
) (
  input  op_e               op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W:0]   result_o
);

  always_comb begin
    result_o = '0;
    case (op_i)
      OP_ADD:  result_o = {1'b0, a_i} + {1'b0, b_i};
      // Wraps modulo 2**(DATA_W+1), so the top bit reads as the borrow.
      OP_SUB:  result_o = {1'b0, a_i} - {1'b0, b_i};
      OP_AND:  result_o = {1'b0, a_i & b_i};
      OP_OR:   result_o = {1'b0, a_i | b_i};
      OP_XOR:  result_o = {1'b0, a_i ^ b_i};
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/scan_alu_unit.sv
// scan_alu_unit -- scan-loaded instruction register driving a small register-file ALU.
// Ports:
//   clk, reset   : rising-edge clock, synchronous active-high reset
//   shift        : shift data_in into the scan register, old MSB goes to data_out
//   update       : copy scan register into the shadow (instruction) register
//   capture      : load z (zero-extended) into the scan register for read-out
//   run          : execute the instruction in the shadow register
//   data_in      : serial scan input
//   data_out     : registered serial scan output, MSB first
//   z            : registered result
//   z_valid      : one-cycle pulse marking that z was written by the previous run edge
// Control priority: reset > shift > update > capture > run.
// Handshake: z/z_valid is a valid-only interface with no ready; a consumer must take z
// in the cycle z_valid is high. There is no backpressure.
module scan_alu_unit
  import scan_alu_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              shift,
  input  logic              update,
  input  logic              capture,
  input  logic              run,
  input  logic              data_in,
  output logic              data_out,
  output logic [DATA_W:0]   z,
  output logic              z_valid
);

  localparam int IW    = calc_iw(DATA_W, ADDR_W);
  localparam int DEPTH = 1 << ADDR_W;

  // Both source addresses are carved out of the payload, so it must hold them.
  if (DATA_W < 2 * ADDR_W) begin : g_bad_params
    $error("scan_alu_unit: DATA_W must be >= 2*ADDR_W");
  end

  logic [IW-1:0]     sr_q, sr_d;
  logic [IW-1:0]     shadow_q, shadow_d;
  logic [DATA_W:0]   z_q, z_d;
  logic              z_valid_q, z_valid_d;
  logic              data_out_q, data_out_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;

  // Instruction field decode
  op_e               op;
  logic [ADDR_W-1:0] dst;
  logic [DATA_W-1:0] pay;
  logic [ADDR_W-1:0] src_a;
  logic [ADDR_W-1:0] src_b;
  logic [DATA_W:0]   alu_res;

  assign op    = op_e'(shadow_q[IW-1 -: OP_W]);
  assign dst   = shadow_q[IW-4 -: ADDR_W];
  assign pay   = shadow_q[DATA_W-1:0];
  assign src_a = pay[2*ADDR_W-1 -: ADDR_W];
  assign src_b = pay[ADDR_W-1:0];

  // Operands come straight from the pre-edge memory, so dst == src reads the old value.
  scan_alu_core #(.DATA_W(DATA_W)) u_core (
    .op_i     (op),
    .a_i      (mem_q[src_a]),
    .b_i      (mem_q[src_b]),
    .result_o (alu_res)
  );

  always_comb begin
    sr_d       = sr_q;
    shadow_d   = shadow_q;
    z_d        = z_q;
    z_valid_d  = 1'b0;
    data_out_d = data_out_q;
    mem_we     = 1'b0;
    mem_wdata  = '0;
    if (shift) begin
      data_out_d = sr_q[IW-1];
      sr_d       = {sr_q[IW-2:0], data_in};
    end else if (update) begin
      shadow_d = sr_q;
    end else if (capture) begin
      sr_d = {{(IW-DATA_W-1){1'b0}}, z_q};
    end else if (run) begin
      case (op)
        OP_WRITE: begin
          mem_we    = 1'b1;
          mem_wdata = pay;
        end
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
          z_d       = alu_res;
          z_valid_d = 1'b1;
          mem_we    = 1'b1;
          mem_wdata = alu_res[DATA_W-1:0];
        end
        OP_BUF: begin
          z_d       = {1'b0, pay};
          z_valid_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q       <= '0;
      shadow_q   <= '0;
      z_q        <= '0;
      z_valid_q  <= 1'b0;
      data_out_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      sr_q       <= sr_d;
      shadow_q   <= shadow_d;
      z_q        <= z_d;
      z_valid_q  <= z_valid_d;
      data_out_q <= data_out_d;
      if (mem_we) begin
        mem_q[dst] <= mem_wdata;
      end
    end
  end

  assign data_out = data_out_q;
  assign z        = z_q;
  assign z_valid  = z_valid_q;

endmodule

// File: tb/tb_scan_alu_unit.sv
module tb_scan_alu_unit;
  localparam int DATA_W = 4;
  localparam int ADDR_W = 2;
  localparam int IW     = 9;
  localparam int DEPTH  = 4;

  logic              clk;
  logic              reset, shift, update, capture, run, data_in;
  logic              data_out, z_valid;
  logic [DATA_W:0]   z;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Reference model: plain integers, scan register as a bit queue (front = MSB)
  int m_mem [DEPTH];
  int m_z, m_zv, m_shadow, m_dout;
  bit m_sr [$];

  scan_alu_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .shift    (shift),
    .update   (update),
    .capture  (capture),
    .run      (run),
    .data_in  (data_in),
    .data_out (data_out),
    .z        (z),
    .z_valid  (z_valid)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, " z"}, 32'(z), m_z);
    check({tag, " z_valid"}, 32'(z_valid), m_zv);
    check({tag, " data_out"}, 32'(data_out), m_dout);
    for (int i = 0; i < DEPTH; i++) begin
      check($sformatf("%s mem[%0d]", tag, i), 32'(dut.mem_q[i]), m_mem[i]);
    end
  endtask

  // ---------------- model ----------------
  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 0;
    m_z = 0; m_zv = 0; m_shadow = 0; m_dout = 0;
    m_sr.delete();
    for (int i = 0; i < IW; i++) m_sr.push_back(1'b0);
  endtask

  function automatic int sr_value();
    int v = 0;
    foreach (m_sr[i]) v = v * 2 + int'(m_sr[i]);
    return v;
  endfunction

  function automatic int enc(input int op, input int dst, input int sa, input int sb);
    return op * 64 + dst * 16 + sa * 4 + sb;
  endfunction

  task automatic model_run();
    int op, dst, pay, a, b, r;
    op  = m_shadow / 64;
    dst = (m_shadow / 16) % 4;
    pay = m_shadow % 16;
    a   = m_mem[pay / 4];
    b   = m_mem[pay % 4];
    r   = 0;
    m_zv = 0;
    case (op)
      0: m_mem[dst] = pay;
      1: r = a + b;
      2: r = (a - b + 32) % 32;
      3: r = a & b;
      4: r = a | b;
      5: r = a ^ b;
      6: begin m_z = pay; m_zv = 1; end
      default: ;
    endcase
    if (op >= 1 && op <= 5) begin
      m_z = r;
      m_mem[dst] = r % 16;
      m_zv = 1;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_shift(input bit b);
    shift = 1'b1; data_in = b;
    tick();
    shift = 1'b0; data_in = 1'b0;
    m_dout = int'(m_sr.pop_front());
    m_sr.push_back(b);
    m_zv = 0;
    check_state("shift");
  endtask

  task automatic do_update();
    update = 1'b1;
    tick();
    update = 1'b0;
    m_shadow = sr_value();
    m_zv = 0;
    check_state("update");
  endtask

  task automatic do_capture();
    capture = 1'b1;
    tick();
    capture = 1'b0;
    m_sr.delete();
    for (int i = IW - 1; i >= 0; i--) m_sr.push_back(bit'((m_z >> i) & 1));
    m_zv = 0;
    check_state("capture");
  endtask

  task automatic do_run();
    run = 1'b1;
    tick();
    run = 1'b0;
    model_run();
    check_state("run");
  endtask

  task automatic do_idle();
    tick();
    m_zv = 0;
    check_state("idle");
  endtask

  task automatic load(input int instr);
    for (int i = IW - 1; i >= 0; i--) do_shift(bit'((instr >> i) & 1));
    do_update();
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    reset = 1'b1; shift = 1'b0; update = 1'b0; capture = 1'b0; run = 1'b0; data_in = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    model_reset();
    check_state("reset");

    // Zero shadow after reset: benign WRITE mem[0] <= 0
    do_run();

    // WRITE mem[1] = 6
    load(enc(0, 1, 1, 2));
    do_run();
    check("req035 mem1", 32'(dut.mem_q[1]), 6);
    check("req035 z_valid", 32'(z_valid), 0);

    // WRITE mem[2] = 0xB, then ADD dst=3 a=1 b=2
    load(enc(0, 2, 2, 3));
    do_run();
    load(enc(1, 3, 1, 2));
    do_run();
    check("req036 z", 32'(z), 32'h11);
    check("req036 z_valid", 32'(z_valid), 1);
    check("req036 mem3", 32'(dut.mem_q[3]), 1);
    do_idle();

    // SUB a=1 b=2 with borrow, then scan the result out
    load(enc(2, 0, 1, 2));
    do_run();
    check("req037 z", 32'(z), 32'h1B);
    do_capture();
    begin
      logic [IW-1:0] exp_bits;
      exp_bits = 9'b0_0001_1011;
      for (int i = IW - 1; i >= 0; i--) begin
        do_shift(1'b0);
        check("req037 scan bit", 32'(data_out), 32'(exp_bits[i]));
      end
    end

    // BUF pay=0xA
    load(enc(6, 0, 2, 2));
    do_run();
    check("req038 buf z", 32'(z), 32'h0A);

    // Held run: repeated accumulation into mem[1]
    load(enc(0, 1, 0, 1));
    do_run();
    load(enc(1, 1, 1, 1));
    run = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      model_run();
      check_state("run_hold");
      check("req038 hold z", 32'(z), 32'(1 << k));
    end
    run = 1'b0;
    do_idle();

    // shift and run together: shift wins
    shift = 1'b1; run = 1'b1; data_in = 1'b1;
    tick();
    shift = 1'b0; run = 1'b0; data_in = 1'b0;
    m_dout = int'(m_sr.pop_front());
    m_sr.push_back(1'b1);
    m_zv = 0;
    check_state("shift_vs_run");

    // update and capture together: update wins, scan register untouched
    update = 1'b1; capture = 1'b1;
    tick();
    update = 1'b0; capture = 1'b0;
    m_shadow = sr_value();
    m_zv = 0;
    check_state("update_vs_capture");

    // Randomized instructions against the model
    for (int n = 0; n < 40; n++) begin
      int op, dst, sa, sb;
      op  = int'($urandom_range(0, 7));
      dst = int'($urandom_range(0, 3));
      sa  = int'($urandom_range(0, 3));
      sb  = int'($urandom_range(0, 3));
      load(enc(op, dst, sa, sb));
      if ($urandom_range(0, 3) == 0) begin
        run = 1'b1;
        for (int k = 0; k < 2; k++) begin
          tick();
          model_run();
          check_state("rand_hold");
        end
        run = 1'b0;
      end else begin
        do_run();
      end
      if ($urandom_range(0, 2) == 0) do_capture();
      if ($urandom_range(0, 2) == 0) do_idle();
    end

    // Reset in the middle of a shift stream
    load(enc(5, 2, 3, 1));
    do_run();
    for (int i = 0; i < 4; i++) do_shift(1'b1);
    reset = 1'b1; shift = 1'b1; data_in = 1'b1;
    tick();
    reset = 1'b0; shift = 1'b0; data_in = 1'b0;
    model_reset();
    check_state("mid_shift_reset");
    for (int i = 0; i < IW; i++) do_shift(1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
